// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   uart_tx_state_t : serializer states
//   UART_DATA_BITS  : data bits per 8N1 frame
//   UART_FRAME_BITS : start + data + stop bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and show-ahead read.
//   sysclk, cpu_reset : clock, asynchronous active-high reset
//   push, push_data   : write request; ignored while full=1
//   pop               : remove head entry; ignored while empty=1
//   pop_data          : current head entry (valid whenever empty=0)
//   full, empty       : registered occupancy flags
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             sysclk,
  input  logic             cpu_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_n;
  logic             push_ok, pop_ok;

  // The flags are registered, so a push seen while full is lost even if a
  // pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop  & ~empty;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_n = count;
    case ({push_ok, pop_ok})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge sysclk or posedge cpu_reset) begin
    if (cpu_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == CNT_FULL);
      empty <= (count_n == '0);
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it was written, and a reset-free array can map onto RAM.
  always_ff @(posedge sysclk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter fed by the memory-access stage byte store.
//   sysclk, cpu_reset : clock, asynchronous active-high reset
//   wr_en, wr_data    : byte write; accepted only while full=0
//   full, empty       : FIFO occupancy flags (registered)
//   busy              : serializer is sending a frame
//   dropped_count     : writes rejected while full, saturating
//   uart_tx           : serial line, idles high, driven from a flop
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int DROP_CNT_W   = 16
) (
  input  logic                  sysclk,
  input  logic                  cpu_reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] dropped_count,
  output logic                  uart_tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            state, state_n;
  logic [BAUD_W-1:0]         baud_cnt, baud_cnt_n;
  logic [BIT_W-1:0]          bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic                      uart_tx_n;
  logic                      pop;
  logic [7:0]                head;
  logic                      bit_end;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk    (sysclk),
    .cpu_reset (cpu_reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign busy    = (state != IDLE);

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + 1'b1;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = head;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          shreg_n    = {1'b0, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == BIT_LAST) begin
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          // A queued byte starts its start bit right after this stop bit.
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = head;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // The line level is decoded from the next state so the flop presents
    // each bit in the same cycle the state machine enters it.
    case (state_n)
      START:   uart_tx_n = 1'b0;
      DATA:    uart_tx_n = shreg_n[0];
      default: uart_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      uart_tx  <= uart_tx_n;
    end
  end

  always_ff @(posedge sysclk or posedge cpu_reset) begin
    if (cpu_reset) begin
      dropped_count <= '0;
    end else if (wr_en && full && (dropped_count != '1)) begin
      dropped_count <= dropped_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed testbench for uart_tx_buffered.
// dut_a: CLKS_PER_BIT=4, 16-bit drop counter (timing, back-to-back, reset, wrap).
// dut_b: CLKS_PER_BIT=16, 4-bit drop counter (overflow and saturation).
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CLK_A = 4;
  localparam int CLK_B = 16;
  localparam int FRAME_A = UART_FRAME_BITS * CLK_A;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        rst_a, wr_en_a, full_a, empty_a, busy_a, tx_a;
  logic [7:0]  wr_data_a;
  logic [15:0] dropped_a;
  logic        rst_b, wr_en_b, full_b, empty_b, busy_b, tx_b;
  logic [7:0]  wr_data_b;
  logic [3:0]  dropped_b;

  int checks = 0;
  int errors = 0;

  uart_tx_buffered #(.CLKS_PER_BIT(CLK_A), .FIFO_DEPTH(16), .DROP_CNT_W(16)) dut_a (
    .sysclk(sysclk), .cpu_reset(rst_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(full_a), .empty(empty_a), .busy(busy_a), .dropped_count(dropped_a),
    .uart_tx(tx_a)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(CLK_B), .FIFO_DEPTH(16), .DROP_CNT_W(4)) dut_b (
    .sysclk(sysclk), .cpu_reset(rst_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .full(full_b), .empty(empty_b), .busy(busy_b), .dropped_count(dropped_b),
    .uart_tx(tx_b)
  );

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  function automatic logic line(input int which);
    return (which == 0) ? tx_a : tx_b;
  endfunction

  task automatic write_a(input logic [7:0] b);
    wr_en_a   = 1'b1;
    wr_data_a = b;
    tick();
    wr_en_a   = 1'b0;
  endtask

  // Receives one frame: finds the first low cycle, then samples mid-bit.
  task automatic rx_frame(input int which, input int clks, output logic [7:0] d, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b1;
    d = '0;
    @(negedge sysclk);
    while (line(which) !== 1'b0 && waited < 30 * clks) begin
      @(negedge sysclk);
      waited++;
    end
    if (line(which) !== 1'b0) begin
      checks++; errors++; ok = 1'b0;
      $display("FAIL rx_start_timeout dut%0d: line=%b, required 0 within %0d cycles", which, line(which), 30 * clks);
      return;
    end
    repeat (clks / 2) @(negedge sysclk);
    checks++;
    if (line(which) !== 1'b0) begin
      errors++; ok = 1'b0;
      $display("FAIL rx_start_bit dut%0d: got %b, required 0", which, line(which));
    end
    for (int i = 0; i < 8; i++) begin
      repeat (clks) @(negedge sysclk);
      d[i] = line(which);
    end
    repeat (clks) @(negedge sysclk);
    checks++;
    if (line(which) !== 1'b1) begin
      errors++; ok = 1'b0;
      $display("FAIL rx_stop_bit dut%0d: got %b, required 1", which, line(which));
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    wr_en_a = 1'b0; wr_data_a = '0;
    wr_en_b = 1'b0; wr_data_b = '0;
    tick(); tick();
    checks++;
    if ({tx_a, full_a, empty_a, busy_a} !== 4'b1010) begin
      errors++; $display("FAIL reset_flags_a: tx/full/empty/busy=%b, required 1010", {tx_a, full_a, empty_a, busy_a});
    end
    checks++;
    if (dropped_a !== 16'd0) begin
      errors++; $display("FAIL reset_dropped_a: got %0d, required 0", dropped_a);
    end
    checks++;
    if ({tx_b, full_b, empty_b, busy_b, dropped_b} !== 8'b1010_0000) begin
      errors++; $display("FAIL reset_b: tx/full/empty/busy/dropped=%b, required 10100000", {tx_b, full_b, empty_b, busy_b, dropped_b});
    end
    rst_a = 1'b0; rst_b = 1'b0;
    tick(); tick();
    checks++;
    if ({tx_a, empty_a, busy_a} !== 3'b110) begin
      errors++; $display("FAIL idle_after_reset: tx/empty/busy=%b, required 110", {tx_a, empty_a, busy_a});
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    int bad_flags;
    frame = {1'b1, 8'h55, 1'b0};
    bad_flags = 0;
    write_a(8'h55);                       // accepted at edge 0
    checks++;
    if (empty_a !== 1'b0) begin
      errors++; $display("FAIL single_empty_after_write: got %b, required 0", empty_a);
    end
    tick();                               // pop at edge 1, start bit begins
    for (int k = 0; k < FRAME_A; k++) begin
      checks++;
      if (tx_a !== frame[k / CLK_A]) begin
        errors++; $display("FAIL single_tx cycle %0d: got %b, required %b", k, tx_a, frame[k / CLK_A]);
      end
      if (busy_a !== 1'b1 || empty_a !== 1'b1) bad_flags++;
      tick();
    end
    checks++;
    if (bad_flags != 0) begin
      errors++; $display("FAIL single_busy_empty: %0d bad cycles, required 0", bad_flags);
    end
    checks++;
    if ({busy_a, tx_a} !== 2'b01) begin
      errors++; $display("FAIL single_end: busy/tx=%b, required 01", {busy_a, tx_a});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic       wave [3 * FRAME_A];
    logic       exp_bit;
    logic [7:0] d;
    int         bad;
    int         b;
    bytes[0] = 8'hA5; bytes[1] = 8'h0F; bytes[2] = 8'hFF;
    bad = 0;
    wr_en_a = 1'b1; wr_data_a = bytes[0];
    tick();
    wr_data_a = bytes[1];
    tick();                               // first start bit begins now
    for (int k = 0; k < 3 * FRAME_A; k++) begin
      wave[k] = tx_a;
      if (k == 0) wr_data_a = bytes[2];
      if (k == 1) wr_en_a = 1'b0;
      tick();
    end
    for (int k = 0; k < 3 * FRAME_A; k++) begin
      b = (k % FRAME_A) / CLK_A;
      if (b == 0)      exp_bit = 1'b0;
      else if (b == 9) exp_bit = 1'b1;
      else             exp_bit = bytes[k / FRAME_A][b - 1];
      if (wave[k] !== exp_bit) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL b2b_waveform: %0d wrong cycles, required 0", bad);
    end
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 8; j++) d[j] = wave[f * FRAME_A + (j + 1) * CLK_A + 2];
      checks++;
      if (d !== bytes[f]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h, required %h", f, d, bytes[f]);
      end
    end
    checks++;
    if ({busy_a, tx_a, empty_a} !== 3'b011) begin
      errors++; $display("FAIL b2b_end: busy/tx/empty=%b, required 011", {busy_a, tx_a, empty_a});
    end
  endtask

  task automatic test_overflow_saturation();
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          wr_en_b = 1'b1; wr_data_b = 8'(8'h10 + i);
          tick();
          if (i == 15) begin
            checks++;
            if (full_b !== 1'b0) begin errors++; $display("FAIL ovf_full_edge15: got %b, required 0", full_b); end
          end
          if (i == 16) begin
            checks++;
            if ({full_b, dropped_b} !== 5'b1_0000) begin
              errors++; $display("FAIL ovf_full_edge16: full/dropped=%b, required 10000", {full_b, dropped_b});
            end
          end
          if (i == 17) begin
            checks++;
            if (dropped_b !== 4'd1) begin errors++; $display("FAIL ovf_dropped: got %0d, required 1", dropped_b); end
          end
        end
        for (int j = 0; j < 20; j++) begin
          wr_data_b = 8'hEE;
          tick();
          if (j == 12) begin
            checks++;
            if (dropped_b !== 4'd14) begin errors++; $display("FAIL sat_dropped_mid: got %0d, required 14", dropped_b); end
          end
        end
        wr_en_b = 1'b0;
        checks++;
        if ({full_b, dropped_b} !== 5'b1_1111) begin
          errors++; $display("FAIL sat_dropped_final: full/dropped=%b, required 11111", {full_b, dropped_b});
        end
      end
      begin
        logic [7:0] d;
        bit ok;
        for (int k = 0; k < 17; k++) begin
          rx_frame(1, CLK_B, d, ok);
          if (ok) begin
            checks++;
            if (d !== 8'(8'h10 + k)) begin
              errors++; $display("FAIL ovf_rx%0d: got %h, required %h", k, d, 8'(8'h10 + k));
            end
          end
        end
      end
    join
    repeat (2 * CLK_B) tick();
    checks++;
    if ({busy_b, empty_b, dropped_b} !== 6'b01_1111) begin
      errors++; $display("FAIL ovf_end: busy/empty/dropped=%b, required 011111", {busy_b, empty_b, dropped_b});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    bit ok;
    write_a(8'hF0); write_a(8'h11); write_a(8'h22); write_a(8'h33); write_a(8'h44);
    repeat (14) tick();                   // after edge 18: data bit 3 of 0xF0
    checks++;
    if ({tx_a, busy_a} !== 2'b01) begin
      errors++; $display("FAIL rst_mid_pre: tx/busy=%b, required 01", {tx_a, busy_a});
    end
    rst_a = 1'b1;
    #1;
    checks++;
    if ({tx_a, empty_a, busy_a, full_a} !== 4'b1100) begin
      errors++; $display("FAIL rst_mid_async: tx/empty/busy/full=%b, required 1100", {tx_a, empty_a, busy_a, full_a});
    end
    tick();
    rst_a = 1'b0;
    tick();
    write_a(8'h3C);
    rx_frame(0, CLK_A, d, ok);
    if (ok) begin
      checks++;
      if (d !== 8'h3C) begin errors++; $display("FAIL rst_mid_rx: got %h, required 3c", d); end
    end
    repeat (3 * CLK_A) tick();
    checks++;
    if ({busy_a, empty_a, tx_a} !== 3'b011) begin
      errors++; $display("FAIL rst_mid_leftover: busy/empty/tx=%b, required 011", {busy_a, empty_a, tx_a});
    end
  endtask

  task automatic test_pointer_wrap();
    for (int burst = 0; burst < 4; burst++) begin
      fork
        begin
          for (int i = 0; i < 10; i++) write_a(8'((burst * 10 + i) * 37 + 5));
        end
        begin
          logic [7:0] d;
          bit ok;
          for (int i = 0; i < 10; i++) begin
            rx_frame(0, CLK_A, d, ok);
            if (ok) begin
              checks++;
              if (d !== 8'((burst * 10 + i) * 37 + 5)) begin
                errors++; $display("FAIL wrap_byte%0d: got %h, required %h", burst * 10 + i, d, 8'((burst * 10 + i) * 37 + 5));
              end
            end
          end
        end
      join
    end
    checks++;
    if (dropped_a !== 16'd0) begin
      errors++; $display("FAIL wrap_dropped: got %0d, required 0", dropped_a);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow_saturation();
    test_reset_mid_frame();
    test_pointer_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
